// File: rtl/reg_skid_buffer_if.sv
// Handshake bundle for reg_skid_buffer: producer enqueue side, consumer dequeue side,
// flush strobe and sticky misuse flags.
interface reg_skid_buffer_if #(
  parameter int width = 1
);
  logic [width-1:0] D_IN;
  logic             ENQ;
  logic             FULL_N;
  logic [width-1:0] D_OUT;
  logic             DEQ;
  logic             EMPTY_N;
  logic             CLR;
  logic             ERR_OVF;
  logic             ERR_UNF;

  modport slave (
    input  D_IN, ENQ, DEQ, CLR,
    output FULL_N, D_OUT, EMPTY_N, ERR_OVF, ERR_UNF
  );

  modport master (
    output D_IN, ENQ, DEQ, CLR,
    input  FULL_N, D_OUT, EMPTY_N, ERR_OVF, ERR_UNF
  );
endinterface

// File: rtl/reg_skid_buffer.sv
// Two-entry registered queue (head + skid) that breaks ready/valid timing paths;
// every output, including FULL_N/EMPTY_N, comes straight from a flop.
module reg_skid_buffer #(
  parameter int               width = 1,
  parameter logic [width-1:0] init  = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  reg_skid_buffer_if.slave     bus,
  output logic [1:0]           count
);

  // Handshake: a word moves in on any edge where ENQ=1 and FULL_N=1, and leaves on
  // any edge where DEQ=1 and EMPTY_N=1. A strobe raised against a deasserted flag is
  // dropped and latches the matching sticky error flag until RST or CLR.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [width-1:0] head, head_nxt;
  logic [width-1:0] skid, skid_nxt;
  logic             full_n, full_n_nxt;
  logic             empty_n, empty_n_nxt;
  logic             ovf, ovf_nxt;
  logic             unf, unf_nxt;
  logic             enq_ok, deq_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_EMPTY;
      head    <= init;
      skid    <= init;
      full_n  <= 1'b1;
      empty_n <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      head    <= head_nxt;
      skid    <= skid_nxt;
      full_n  <= full_n_nxt;
      empty_n <= empty_n_nxt;
      ovf     <= ovf_nxt;
      unf     <= unf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    enq_ok    = bus.ENQ && (state != S_TWO);
    deq_ok    = bus.DEQ && (state != S_EMPTY);
    ovf_nxt   = ovf || (bus.ENQ && (state == S_TWO));
    unf_nxt   = unf || (bus.DEQ && (state == S_EMPTY));

    case (state)
      S_EMPTY: begin
        if (enq_ok) begin
          head_nxt  = bus.D_IN;
          state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (enq_ok && deq_ok) begin
          head_nxt = bus.D_IN;
        end else if (enq_ok) begin
          skid_nxt  = bus.D_IN;
          state_nxt = S_TWO;
        end else if (deq_ok) begin
          head_nxt  = init;
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        // An ENQ here is never accepted, so only DEQ can move the queue.
        if (deq_ok) begin
          head_nxt  = skid;
          skid_nxt  = init;
          state_nxt = S_ONE;
        end
      end
      default: begin
        head_nxt  = init;
        skid_nxt  = init;
        state_nxt = S_EMPTY;
      end
    endcase

    if (bus.CLR) begin
      state_nxt = S_EMPTY;
      head_nxt  = init;
      skid_nxt  = init;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
    end

    full_n_nxt  = (state_nxt != S_TWO);
    empty_n_nxt = (state_nxt != S_EMPTY);
  end

  assign bus.D_OUT   = head;
  assign bus.FULL_N  = full_n;
  assign bus.EMPTY_N = empty_n;
  assign bus.ERR_OVF = ovf;
  assign bus.ERR_UNF = unf;
  assign count       = state;

endmodule

// File: tb/tb_reg_skid_buffer.sv
// Directed bench for reg_skid_buffer: reset, fill/drain, streaming, overflow,
// underflow and flush, each step checked against hand-computed values.
module tb_reg_skid_buffer;

  localparam int         W    = 8;
  localparam logic [7:0] INIT = 8'h5A;

  logic       clk;
  logic       rst;
  logic [1:0] count;
  int         vectors;
  int         miscompares;
  logic [W-1:0] exp_q[$];

  reg_skid_buffer_if #(.width(W)) bus ();

  reg_skid_buffer #(.width(W), .init(INIT)) dut (
    .CLK   (clk),
    .RST   (rst),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic c, input logic e,
                       input logic [W-1:0] din, input logic d);
    rst         = r;
    bus.CLR     = c;
    bus.ENQ     = e;
    bus.D_IN    = din;
    bus.DEQ     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] dout, input logic en,
                         input logic fn, input logic ov, input logic un,
                         input logic [1:0] cnt);
    chk({tag, ".d_out"},   32'(bus.D_OUT),   32'(dout));
    chk({tag, ".empty_n"}, 32'(bus.EMPTY_N), 32'(en));
    chk({tag, ".full_n"},  32'(bus.FULL_N),  32'(fn));
    chk({tag, ".err_ovf"}, 32'(bus.ERR_OVF), 32'(ov));
    chk({tag, ".err_unf"}, 32'(bus.ERR_UNF), 32'(un));
    chk({tag, ".count"},   32'(count),       32'(cnt));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; bus.CLR = 1'b0; bus.ENQ = 1'b0; bus.DEQ = 1'b0; bus.D_IN = '0;

    // Reset dominates active strobes
    drive(1, 0, 1, 8'h05, 1);
    chk_all("rst1", INIT, 0, 1, 0, 0, 2'd0);
    drive(1, 0, 1, 8'h05, 1);
    chk_all("rst2", INIT, 0, 1, 0, 0, 2'd0);
    drive(0, 0, 0, 8'h00, 0);
    chk_all("rst_idle", INIT, 0, 1, 0, 0, 2'd0);

    // Fill and drain
    drive(0, 0, 1, 8'h11, 0);
    chk_all("fill1", 8'h11, 1, 1, 0, 0, 2'd1);
    drive(0, 0, 1, 8'h22, 0);
    chk_all("fill2", 8'h11, 1, 0, 0, 0, 2'd2);
    drive(0, 0, 0, 8'h00, 1);
    chk_all("drain1", 8'h22, 1, 1, 0, 0, 2'd1);
    drive(0, 0, 0, 8'h00, 1);
    chk_all("drain2", INIT, 0, 1, 0, 0, 2'd0);

    // Streaming: prime with 1, then ENQ+DEQ with 2..100, drain the last word
    drive(0, 0, 1, 8'd1, 0);
    exp_q.push_back(8'd1);
    chk_all("stream_prime", 8'd1, 1, 1, 0, 0, 2'd1);
    for (int i = 2; i <= 100; i++) begin
      chk("stream_head", 32'(bus.D_OUT), 32'(exp_q.pop_front()));
      exp_q.push_back(W'(i));
      drive(0, 0, 1, W'(i), 1);
      chk("stream_dout",  32'(bus.D_OUT), 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    chk("stream_last", 32'(bus.D_OUT), 32'(exp_q.pop_front()));
    chk("stream_qempty", 32'(exp_q.size()), 32'd0);
    drive(0, 0, 0, 8'h00, 1);
    chk_all("stream_done", INIT, 0, 1, 0, 0, 2'd0);

    // Overflow: third word dropped, flag sticky
    drive(0, 0, 1, 8'hA1, 0);
    drive(0, 0, 1, 8'hA2, 0);
    chk_all("ovf_full", 8'hA1, 1, 0, 0, 0, 2'd2);
    drive(0, 0, 1, 8'hA3, 0);
    chk_all("ovf_set", 8'hA1, 1, 0, 1, 0, 2'd2);
    drive(0, 0, 0, 8'h00, 0);
    chk_all("ovf_hold", 8'hA1, 1, 0, 1, 0, 2'd2);
    drive(0, 0, 0, 8'h00, 1);
    chk_all("ovf_drain1", 8'hA2, 1, 1, 1, 0, 2'd1);
    drive(0, 0, 0, 8'h00, 1);
    chk_all("ovf_drain2", INIT, 0, 1, 1, 0, 2'd0);

    // CLR on empty clears the sticky flag
    drive(0, 1, 0, 8'h00, 0);
    chk_all("clr_empty", INIT, 0, 1, 0, 0, 2'd0);

    // Underflow with simultaneous legal ENQ
    drive(0, 0, 1, 8'h3C, 1);
    chk_all("unf", 8'h3C, 1, 1, 0, 1, 2'd1);

    // Build count2 with both flags, including ENQ+DEQ while full
    drive(0, 0, 1, 8'h44, 0);
    chk_all("mid_fill", 8'h3C, 1, 0, 0, 1, 2'd2);
    drive(0, 0, 1, 8'h99, 1);
    chk_all("full_enq_deq", 8'h44, 1, 1, 1, 1, 2'd1);
    drive(0, 0, 1, 8'h55, 0);
    chk_all("refill", 8'h44, 1, 0, 1, 1, 2'd2);

    // CLR mid-operation discards strobes and clears flags
    drive(0, 1, 1, 8'h77, 1);
    chk_all("clr_mid", INIT, 0, 1, 0, 0, 2'd0);
    drive(0, 0, 0, 8'h00, 0);
    chk_all("clr_idle", INIT, 0, 1, 0, 0, 2'd0);

    // RST with CLR behaves as reset
    drive(0, 0, 1, 8'h61, 0);
    drive(0, 0, 1, 8'h62, 0);
    drive(0, 0, 1, 8'h63, 1);
    drive(0, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 8'h00, 1);
    chk_all("pre_rstclr", INIT, 0, 1, 1, 1, 2'd0);
    drive(1, 1, 1, 8'h88, 1);
    chk_all("rst_clr", INIT, 0, 1, 0, 0, 2'd0);
    drive(0, 0, 1, 8'hC3, 0);
    chk_all("post_rst", 8'hC3, 1, 1, 0, 0, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
